// File: rtl/div.sv
// Iterative signed 32-bit divider: one restoring-division step per clock,
// quotient truncates toward zero, completion flagged by a one-cycle data_resultRDY pulse.
module div #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [2*WIDTH-1:0]   rq_q;     // {remainder, quotient}
  logic [WIDTH-1:0]     dvs_q;
  logic                 sign_q;
  logic                 exc_q;
  logic                 dz_q;

  logic [WIDTH-1:0]     abs_a, abs_b;
  logic                 div_zero, overflow;
  logic [2*WIDTH-1:0]   shifted, step_rq;
  logic [WIDTH:0]       trial;
  logic [WIDTH-1:0]     quo, res_val;

  // |0x80000000| wraps back to 0x80000000, which is correct as an unsigned magnitude.
  always_comb begin
    abs_a    = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
    abs_b    = data_operandB[WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB;
    div_zero = (data_operandB == '0);
    overflow = (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (data_operandB == '1);
  end

  // Borrow out of the 33-bit subtract decides the quotient bit.
  always_comb begin
    shifted = {rq_q[2*WIDTH-2:0], 1'b0};
    trial   = {1'b0, shifted[2*WIDTH-1:WIDTH]} - {1'b0, dvs_q};
    if (trial[WIDTH]) begin
      step_rq = shifted;
    end else begin
      step_rq = {trial[WIDTH-1:0], shifted[WIDTH-1:1], 1'b1};
    end
  end

  always_comb begin
    quo = rq_q[WIDTH-1:0];
    if (dz_q) begin
      res_val = '0;
    end else if (sign_q) begin
      res_val = ~quo + 1'b1;
    end else begin
      res_val = quo;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (ctrl_DIV) state_d = StRun;
      StRun: begin
        if (ctrl_DIV) begin
          state_d = StRun;
        end else if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = ctrl_DIV ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign busy = (state_q != StIdle);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      rq_q           <= '0;
      dvs_q          <= '0;
      sign_q         <= 1'b0;
      exc_q          <= 1'b0;
      dz_q           <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      state_q        <= state_d;
      data_resultRDY <= 1'b0;
      if (state_q == StDone) begin
        data_result    <= res_val;
        data_exception <= exc_q;
        data_resultRDY <= 1'b1;
      end
      if (ctrl_DIV) begin
        rq_q   <= {{WIDTH{1'b0}}, abs_a};
        dvs_q  <= abs_b;
        sign_q <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        exc_q  <= div_zero | overflow;
        dz_q   <= div_zero;
        cnt_q  <= '0;
        // A start in the DONE cycle must not wipe the result being delivered.
        if (state_q != StDone) begin
          data_result    <= '0;
          data_exception <= 1'b0;
        end
      end else if (state_q == StRun) begin
        rq_q  <= step_rq;
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: directed vector table, multi-cycle corner sequences
// and a random sweep against a signed truncating-division model.
module tb_div;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] data_operandA, data_operandB;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY, busy;

  int total = 0;
  int bad   = 0;

  div #(.WIDTH(32), .CNT_W(6)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        exc;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  // Leaves the bench at the falling edge right after the start edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_DIV      = 1'b1;
    @(negedge clock);
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  // lat = number of rising edges after the start edge until RDY is seen; -1 on timeout.
  task automatic wait_rdy(output int lat, output bit busy_ok);
    lat     = -1;
    busy_ok = busy;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (data_resultRDY) begin
        lat = k;
        if (busy) busy_ok = 1'b0;
        break;
      end else if (!busy) begin
        busy_ok = 1'b0;
      end
    end
  endtask

  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic e);
    if (b == 32'd0) begin
      r = 32'd0;
      e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = 32'h8000_0000;
      e = 1'b1;
    end else begin
      r = $signed(a) / $signed(b);
      e = 1'b0;
    end
  endfunction

  vec_t vecs[$];

  initial begin
    int          lat;
    bit          bok;
    logic [31:0] mr;
    logic        me;
    logic [31:0] ra, rb;
    int          seen;

    vecs.push_back('{32'd100,       32'd7,         32'd14,        1'b0});
    vecs.push_back('{32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 1'b0});
    vecs.push_back('{32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0});
    vecs.push_back('{32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        1'b0});
    vecs.push_back('{32'd7,         32'd100,       32'd0,         1'b0});
    vecs.push_back('{32'd1234,      32'd0,         32'd0,         1'b1});
    vecs.push_back('{32'd8,         32'd2,         32'd4,         1'b0});
    vecs.push_back('{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1});
    vecs.push_back('{32'h8000_0000, 32'd1,         32'h8000_0000, 1'b0});
    vecs.push_back('{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd1,         1'b0});
    vecs.push_back('{32'd0,         32'hFFFF_FFFB, 32'd0,         1'b0});
    vecs.push_back('{32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0});
    vecs.push_back('{32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         1'b0});
    vecs.push_back('{32'h8000_0000, 32'h8000_0000, 32'd1,         1'b0});
    vecs.push_back('{32'hFFFF_FFFF, 32'd0,         32'd0,         1'b1});

    reset         = 1'b1;
    ctrl_DIV      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (2) @(negedge clock);
    chk("reset_result", data_result, 32'd0);
    chk("reset_exc",    {31'd0, data_exception}, 32'd0);
    chk("reset_rdy",    {31'd0, data_resultRDY}, 32'd0);
    chk("reset_busy",   {31'd0, busy}, 32'd0);

    // Reset wins over a simultaneous start.
    ctrl_DIV = 1'b1;
    data_operandA = 32'd9;
    data_operandB = 32'd3;
    @(negedge clock);
    ctrl_DIV = 1'b0;
    reset    = 1'b0;
    chk("reset_beats_start_busy", {31'd0, busy}, 32'd0);

    foreach (vecs[i]) begin
      start_op(vecs[i].a, vecs[i].b);
      wait_rdy(lat, bok);
      chk($sformatf("vec%0d_latency", i), lat, 33);
      chk($sformatf("vec%0d_busy", i), {31'd0, bok}, 32'd1);
      chk($sformatf("vec%0d_result", i), data_result, vecs[i].res);
      chk($sformatf("vec%0d_exc", i), {31'd0, data_exception}, {31'd0, vecs[i].exc});
      @(negedge clock);
      chk($sformatf("vec%0d_rdy_one_cycle", i), {31'd0, data_resultRDY}, 32'd0);
      chk($sformatf("vec%0d_result_held", i), data_result, vecs[i].res);
    end

    // Restart while busy: only the second operation reports.
    start_op(32'd50, 32'd5);
    seen = 0;
    repeat (9) begin
      @(negedge clock);
      if (data_resultRDY) seen++;
    end
    start_op(32'd81, 32'd9);
    if (data_resultRDY) seen++;
    wait_rdy(lat, bok);
    chk("restart_early_rdy", seen, 0);
    chk("restart_latency", lat, 33);
    chk("restart_result", data_result, 32'd9);

    // Start in the DONE cycle: old pulse still fires, new op runs full latency.
    start_op(32'd100, 32'd7);
    seen = 0;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clock);
      if (data_resultRDY) seen++;
    end
    data_operandA = 32'd81;
    data_operandB = 32'hFFFF_FFF7;
    ctrl_DIV      = 1'b1;
    @(negedge clock);
    ctrl_DIV = 1'b0;
    chk("done_start_early_rdy", seen, 0);
    chk("done_start_old_rdy", {31'd0, data_resultRDY}, 32'd1);
    chk("done_start_old_result", data_result, 32'd14);
    chk("done_start_busy", {31'd0, busy}, 32'd1);
    wait_rdy(lat, bok);
    chk("done_start_new_latency", lat, 33);
    chk("done_start_new_result", data_result, 32'hFFFF_FFF7);

    // Reset in idle clears a held nonzero result.
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("idle_reset_result", data_result, 32'd0);

    // Divide by zero leaves exc set; reset mid-run must clear it and suppress RDY.
    start_op(32'd5, 32'd0);
    wait_rdy(lat, bok);
    chk("dz_exc_before_abort", {31'd0, data_exception}, 32'd1);
    start_op(32'd1000, 32'd10);
    repeat (10) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("abort_result", data_result, 32'd0);
    chk("abort_exc", {31'd0, data_exception}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clock);
      if (data_resultRDY || busy) seen++;
    end
    chk("abort_no_rdy", seen, 0);
    start_op(32'd8, 32'd2);
    wait_rdy(lat, bok);
    chk("after_abort_result", data_result, 32'd4);

    for (int n = 0; n < 1000; n++) begin
      ra = $urandom;
      rb = $urandom;
      if (n % 3 == 1) rb = $signed(rb) >>> $urandom_range(31, 8);
      if (n % 7 == 2) ra = $signed(ra) >>> $urandom_range(31, 0);
      model(ra, rb, mr, me);
      start_op(ra, rb);
      wait_rdy(lat, bok);
      total++;
      if (lat != 33 || data_result !== mr || data_exception !== me) begin
        bad++;
        $display("FAIL rand%0d %h/%h: got %h exc %b lat %0d want %h exc %b lat 33",
                 n, ra, rb, data_result, data_exception, lat, mr, me);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
